// File: rtl/stp_packer.sv
// stp_packer: collects 16 real samples into a frame of complex words.
// A capture bank fills one sample per accepted cycle; the 16th sample
// copies the frame into an output bank that holds until the next frame
// completes, so a downstream consumer sees stable data after stp_valid.
module stp_packer #(
  parameter int unsigned DW = 16,
  parameter int unsigned N  = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          fir_valid,
  input  logic [DW-1:0] fir_d,
  input  logic          flush,
  output logic          stp_valid,
  output logic [31:0]   in_d0,
  output logic [31:0]   in_d1,
  output logic [31:0]   in_d2,
  output logic [31:0]   in_d3,
  output logic [31:0]   in_d4,
  output logic [31:0]   in_d5,
  output logic [31:0]   in_d6,
  output logic [31:0]   in_d7,
  output logic [31:0]   in_d8,
  output logic [31:0]   in_d9,
  output logic [31:0]   in_d10,
  output logic [31:0]   in_d11,
  output logic [31:0]   in_d12,
  output logic [31:0]   in_d13,
  output logic [31:0]   in_d14,
  output logic [31:0]   in_d15,
  output logic [7:0]    frame_cnt,
  output logic [3:0]    fill_lvl
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IM_W   = 16;
  localparam int unsigned RE_W   = WORD_W - IM_W;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned LVL_W  = 4;
  localparam logic [LVL_W-1:0] LAST_IDX = LVL_W'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [LVL_W-1:0]  fill_q, fill_d;
  logic              accept_c;
  logic              complete_c;
  logic [RE_W-1:0]   sample_c;
  logic [RE_W-1:0]   cap_q [N];
  logic [RE_W-1:0]   out_q [N];
  logic [CNT_W-1:0]  cnt_q;
  logic              vld_q;

  // Real part of the incoming sample, passed through unmodified.
  assign sample_c = RE_W'(fir_d);

  // Flush wins over a coincident sample: the sample is dropped.
  assign accept_c = fir_valid & ~flush;

  // Next-state logic: fill level tracking and frame-complete detection.
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    complete_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_FILL;
          fill_d  = LVL_W'(1);
        end
      end
      S_FILL: begin
        if (flush) begin
          state_d = S_IDLE;
          fill_d  = '0;
        end else if (fir_valid) begin
          if (fill_q == LAST_IDX) begin
            complete_c = 1'b1;
            state_d    = S_IDLE;
            fill_d     = '0;
          end else begin
            fill_d = fill_q + LVL_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        fill_d  = '0;
      end
    endcase
  end

  // FSM state and fill level registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Capture bank: accepted sample lands at the current fill index.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < N; i++) begin
        cap_q[i] <= '0;
      end
    end else if (accept_c) begin
      cap_q[fill_q] <= sample_c;
    end
  end

  // Output bank: loaded only when a frame completes, the last word comes
  // straight from the input so no extra cycle of latency is added.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < N; i++) begin
        out_q[i] <= '0;
      end
    end else if (complete_c) begin
      for (int unsigned i = 0; i < N - 1; i++) begin
        out_q[i] <= cap_q[i];
      end
      out_q[N-1] <= sample_c;
    end
  end

  // Frame strobe and wrapping frame counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      vld_q <= complete_c;
      if (complete_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Frame words: real part on top, imaginary part tied to zero.
  assign in_d0  = {out_q[0],  {IM_W{1'b0}}};
  assign in_d1  = {out_q[1],  {IM_W{1'b0}}};
  assign in_d2  = {out_q[2],  {IM_W{1'b0}}};
  assign in_d3  = {out_q[3],  {IM_W{1'b0}}};
  assign in_d4  = {out_q[4],  {IM_W{1'b0}}};
  assign in_d5  = {out_q[5],  {IM_W{1'b0}}};
  assign in_d6  = {out_q[6],  {IM_W{1'b0}}};
  assign in_d7  = {out_q[7],  {IM_W{1'b0}}};
  assign in_d8  = {out_q[8],  {IM_W{1'b0}}};
  assign in_d9  = {out_q[9],  {IM_W{1'b0}}};
  assign in_d10 = {out_q[10], {IM_W{1'b0}}};
  assign in_d11 = {out_q[11], {IM_W{1'b0}}};
  assign in_d12 = {out_q[12], {IM_W{1'b0}}};
  assign in_d13 = {out_q[13], {IM_W{1'b0}}};
  assign in_d14 = {out_q[14], {IM_W{1'b0}}};
  assign in_d15 = {out_q[15], {IM_W{1'b0}}};

  assign stp_valid = vld_q;
  assign frame_cnt = cnt_q;
  assign fill_lvl  = fill_q;

endmodule

// File: tb/tb_stp_packer.sv
// Bench for stp_packer: table of frame vectors plus hand-written flush,
// reset, back-to-back and counter-wrap sequences; a behavioural model
// pushes expected frames to a queue that a monitor pops on stp_valid.
module tb_stp_packer;

  logic        CLK;
  logic        RST;
  logic        fir_valid;
  logic [15:0] fir_d;
  logic        flush;
  logic        stp_valid;
  logic [31:0] in_d0, in_d1, in_d2, in_d3, in_d4, in_d5, in_d6, in_d7;
  logic [31:0] in_d8, in_d9, in_d10, in_d11, in_d12, in_d13, in_d14, in_d15;
  logic [7:0]  frame_cnt;
  logic [3:0]  fill_lvl;

  stp_packer #(.DW(16), .N(16)) dut (
    .CLK(CLK), .RST(RST), .fir_valid(fir_valid), .fir_d(fir_d), .flush(flush),
    .stp_valid(stp_valid),
    .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
    .in_d4(in_d4), .in_d5(in_d5), .in_d6(in_d6), .in_d7(in_d7),
    .in_d8(in_d8), .in_d9(in_d9), .in_d10(in_d10), .in_d11(in_d11),
    .in_d12(in_d12), .in_d13(in_d13), .in_d14(in_d14), .in_d15(in_d15),
    .frame_cnt(frame_cnt), .fill_lvl(fill_lvl)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] dut_w [16];
  assign dut_w[0]  = in_d0;  assign dut_w[1]  = in_d1;
  assign dut_w[2]  = in_d2;  assign dut_w[3]  = in_d3;
  assign dut_w[4]  = in_d4;  assign dut_w[5]  = in_d5;
  assign dut_w[6]  = in_d6;  assign dut_w[7]  = in_d7;
  assign dut_w[8]  = in_d8;  assign dut_w[9]  = in_d9;
  assign dut_w[10] = in_d10; assign dut_w[11] = in_d11;
  assign dut_w[12] = in_d12; assign dut_w[13] = in_d13;
  assign dut_w[14] = in_d14; assign dut_w[15] = in_d15;

  typedef struct packed {
    logic [7:0]        cnt;
    logic [15:0][15:0] s;
  } frame_t;

  typedef struct {
    string       name;
    int          pre_n;
    logic [15:0] s0;
    logic [15:0] s1;
    logic [15:0] base;
    logic [15:0] stride;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e15;
  } vec_t;

  int                n_chk  = 0;
  int                n_pass = 0;
  frame_t            exp_q[$];
  int                pulse_cyc[$];
  int                cyc = 0;
  logic [15:0][15:0] held;
  logic [15:0][15:0] mbuf;
  int                mfill = 0;
  logic [7:0]        mcnt  = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One input cycle: drive, update the model, clock, verify fill level.
  task automatic step(input logic v, input logic [15:0] d, input logic f);
    frame_t fr;
    fir_valid = v;
    fir_d     = d;
    flush     = f;
    if (f) begin
      mfill = 0;
    end else if (v) begin
      mbuf[mfill] = d;
      if (mfill == 15) begin
        mcnt   = mcnt + 8'd1;
        fr.cnt = mcnt;
        fr.s   = mbuf;
        exp_q.push_back(fr);
        mfill  = 0;
      end else begin
        mfill++;
      end
    end
    @(posedge CLK);
    #1;
    fir_valid = 1'b0;
    flush     = 1'b0;
    check("fill_lvl", 32'(fill_lvl), 32'(mfill));
  endtask

  function automatic logic [15:0] row_sample(input vec_t r, input int k);
    if (k == 0) return r.s0;
    if (k == 1) return r.s1;
    return 16'(r.base + 16'(k) * r.stride);
  endfunction

  // Monitor: score each frame strobe, otherwise demand the output bank holds.
  always @(negedge CLK) begin
    if (!RST) begin
      held = '0;
    end else begin
      cyc++;
      if (stp_valid) begin
        pulse_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(stp_valid), 32'd0);
        end else begin
          frame_t fr;
          fr = exp_q.pop_front();
          for (int i = 0; i < 16; i++) check($sformatf("frame_w%0d", i), dut_w[i], {fr.s[i], 16'h0000});
          check("frame_cnt", 32'(frame_cnt), 32'(fr.cnt));
          held = fr.s;
        end
      end else begin
        int k;
        k = 0;
        for (int i = 15; i >= 0; i--) if (dut_w[i] !== {held[i], 16'h0000}) k = i;
        check("hold", dut_w[k], {held[k], 16'h0000});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    vt[0] = '{"ramp",     0, 16'h0001, 16'h0002, 16'h0001, 16'h0001, 32'h0001_0000, 32'h0002_0000, 32'h0010_0000};
    vt[1] = '{"negative", 0, 16'h8000, 16'hFFFF, 16'h1234, 16'h0101, 32'h8000_0000, 32'hFFFF_0000, 32'h2143_0000};
    vt[2] = '{"extremes", 0, 16'h7FFF, 16'h0000, 16'h7FF0, 16'h0001, 32'h7FFF_0000, 32'h0000_0000, 32'h7FFF_0000};
    vt[3] = '{"flushed",  7, 16'hA000, 16'hA001, 16'hA000, 16'h0001, 32'hA000_0000, 32'hA001_0000, 32'hA00F_0000};

    RST = 1'b0; fir_valid = 1'b0; fir_d = '0; flush = 1'b0;
    #3;
    check("rst_valid", 32'(stp_valid), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);
    check("rst_fill", 32'(fill_lvl), 32'd0);
    check("rst_d0", in_d0, 32'd0);
    @(negedge CLK); @(negedge CLK); #1;
    RST = 1'b1;

    // Table-driven frames.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < vt[r].pre_n; i++) step(1'b1, 16'(16'h5500 + i), 1'b0);
      if (vt[r].pre_n > 0) step(1'b1, 16'hDEAD, 1'b1);
      for (int k = 0; k < 16; k++) step(1'b1, row_sample(vt[r], k), 1'b0);
      check({vt[r].name, "_valid"}, 32'(stp_valid), 32'd1);
      check({vt[r].name, "_d0"}, in_d0, vt[r].e0);
      check({vt[r].name, "_d1"}, in_d1, vt[r].e1);
      check({vt[r].name, "_d15"}, in_d15, vt[r].e15);
      check({vt[r].name, "_cnt"}, 32'(frame_cnt), 32'(r + 1));
      step(1'b0, 16'hFFFF, 1'b0);
      check({vt[r].name, "_pulse_end"}, 32'(stp_valid), 32'd0);
    end

    // Back-to-back frames: strobes exactly 16 cycles apart.
    pulse_cyc.delete();
    for (int i = 0; i < 32; i++) step(1'b1, 16'($urandom), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("b2b_pulses", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() == 2) check("b2b_gap", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd16);

    // Flush alone mid-frame, then flush while idle.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h3300 + i), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);

    // Reset mid-frame clears everything asynchronously.
    for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h7700 + i), 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check("mrst_valid", 32'(stp_valid), 32'd0);
    check("mrst_d0", in_d0, 32'd0);
    check("mrst_d15", in_d15, 32'd0);
    check("mrst_cnt", 32'(frame_cnt), 32'd0);
    check("mrst_fill", 32'(fill_lvl), 32'd0);
    exp_q.delete();
    mfill = 0;
    mcnt  = 8'd0;
    @(negedge CLK); #1;
    RST = 1'b1;
    for (int k = 0; k < 16; k++) step(1'b1, 16'(16'hC000 + k), 1'b0);
    check("post_rst_d0", in_d0, 32'hC000_0000);
    check("post_rst_cnt", 32'(frame_cnt), 32'd1);

    // Random gaps until the frame counter wraps to zero.
    for (int n = 0; n < 30000 && mcnt != 8'd0; n++) step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'b0);
    step(1'b0, 16'h0, 1'b0);
    check("wrap_cnt", 32'(frame_cnt), 32'd0);
    check("wrap_model", 32'(mcnt), 32'd0);

    step(1'b0, 16'h0, 1'b0);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stp_packer.md
STP_PACKER -- requirements
Module: stp_packer

Interface
REQ-001 SHALL have parameter DW, default 16: width of one signed real input sample.
REQ-002 SHALL have parameter N, default 16: samples per frame; only 16 is supported.
REQ-003 SHALL have port CLK  input  1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1: reset, asynchronous, active-low (asserted when 0).
REQ-005 SHALL have port fir_valid  input  1: fir_d carries a valid sample this cycle; at most one sample per cycle; no backpressure.
REQ-006 SHALL have port fir_d  input  DW: signed two's-complement real sample.
REQ-007 SHALL have port flush  input  1: synchronous discard of any partial frame.
REQ-008 SHALL have port stp_valid  output  1: one-cycle pulse; a complete frame is on in_d0..in_d15.
REQ-009 SHALL have ports in_d0..in_d15  output  32 each: frame word k; [31:16] = sample k, [15:0] = 16'h0000 (imaginary part).
REQ-010 SHALL have port frame_cnt  output  8: count of completed frames, wraps 255 -> 0.
REQ-011 SHALL have port fill_lvl  output  4: number of samples currently held in the partial frame.

Function
REQ-012 SHALL hold two banks: a 16-entry capture bank and a 16-word output bank driving in_d0..in_d15.
REQ-013 SHALL run a 2-state FSM: IDLE (fill_lvl = 0) and FILL (1 <= fill_lvl <= 15).
REQ-014 SHALL move IDLE -> FILL on an accepted sample with flush = 0.
REQ-015 SHALL stay in FILL on accepted samples while fill_lvl < 15.
REQ-016 SHALL return FILL -> IDLE on the 16th accepted sample, or on flush.
REQ-017 SHALL write each accepted sample to capture index fill_lvl, then increment fill_lvl; the first sample of a frame maps to in_d0 and the 16th to in_d15, in natural order with no reordering.
REQ-018 SHALL, on the edge that accepts the 16th sample, copy entries 0..14 plus the current fir_d into the output bank.
REQ-019 SHALL, on that same edge, set stp_valid to 1 for exactly one cycle, increment frame_cnt, and clear fill_lvl to 0.
REQ-020 SHALL give a latency of 1 edge from the 16th sample at the input to stp_valid = 1 with data already updated.
REQ-021 SHALL hold in_d0..in_d15 stable from that edge until the next frame completes, a minimum of 16 cycles, so that a downstream registered-valid consumer sampling one cycle after stp_valid sees unchanged data.
REQ-022 SHALL place fir_d in [31:16] unmodified, with no sign extension into [15:0], and force [15:0] to zero.
REQ-023 SHALL support back-to-back frames: the 1st sample of frame n+1 may arrive on the cycle right after the 16th sample of frame n, with no loss.
REQ-024 SHALL give flush priority when flush = 1 and fir_valid = 1 in the same cycle: the sample is discarded and fill_lvl becomes 0.
REQ-025 SHALL NOT let flush alter the output bank, frame_cnt, or an already-registered stp_valid pulse.
REQ-026 SHALL ignore fir_d whenever fir_valid = 0; gaps of any length between samples are allowed.
REQ-027 SHALL preserve the 8-bit frame_cnt across wrap: 255 + 1 = 0, with no other side effect.

Reset
REQ-028 SHALL, while RST = 0, asynchronously force stp_valid = 0, in_d0..in_d15 = 0, frame_cnt = 0, fill_lvl = 0, FSM = IDLE, and clear the capture bank to 0.
REQ-029 SHALL, if reset asserts mid-frame, discard the partial frame; the first accepted sample after release becomes in_d0.
REQ-030 SHALL accept a sample on the first rising edge after RST returns to 1.

Verification
REQ-031 SHALL cover: 16 consecutive valid samples 0x0001..0x0010 -> stp_valid high one cycle after the 16th; in_d0 = 0x00010000; in_d15 = 0x00100000; frame_cnt = 1; fill_lvl = 0.
REQ-032 SHALL cover: negative samples 0x8000 and 0xFFFF at positions 0 and 1 -> in_d0 = 0x80000000, in_d1 = 0xFFFF0000.
REQ-033 SHALL cover: 32 back-to-back samples -> two stp_valid pulses exactly 16 cycles apart; frame-1 data held unchanged for all 16 cycles between them.
REQ-034 SHALL cover: 7 samples, then flush asserted together with a valid sample, then 16 samples 0xA000..0xA00F -> one stp_valid; in_d0 = 0xA0000000; the discarded sample is absent.
REQ-035 SHALL cover: RST pulled low after 10 samples -> all outputs 0 immediately; after release, 16 samples produce a frame whose in_d0 is the first post-reset sample.
REQ-036 SHALL cover: 256 frames with random fir_valid gaps -> frame_cnt wraps to 0; every frame matches the reference model.
